cpu_dmem_system: RTL and testbench
==================================

Name: cpu_dmem_system

Overview:
- 8-bit single-cycle CPU core with an internal 256-byte data memory. The data memory has a multi-cycle busywait handshake.
- Instruction memory is external. The block drives PC and receives a 32-bit INSTRUCTION word combinationally.
- Top-level processor block; the instruction ROM and the bench sit around it.

Parameters:
- MEM_LATENCY, 5, clock cycles per data-memory access (>=2)
- DMEM_DEPTH, 256, data memory bytes (8-bit address)

Ports:
- CLK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- PC  output  32  byte address of current instruction
- INSTRUCTION  input  32  instruction word at PC, valid combinationally

Behaviour:
- Clock and reset: one clock (CLK). RESET is asynchronous and active-high.
- Reset (asynchronous, while RESET=1):
  - PC=0.
  - Registers r0..r7=0.
  - Data memory bytes=0.
  - Memory counter=0.
  - Internal READ/WRITE/BUSYWAIT=0.
- Instruction format:
  - [31:24] opcode
  - [23:16] RD or jump/branch offset
  - [15:8] RS1
  - [7:0] RS2 or IMM
  - Register indices use the low 3 bits of each field.
- Opcodes:
  - 0x00 loadi: RD=IMM
  - 0x01 mov: RD=R[RS2]
  - 0x02 add: RD=R[RS1]+R[RS2] (mod 256)
  - 0x03 sub: RD=R[RS1]-R[RS2] (two's complement, mod 256)
  - 0x04 and: RD=R[RS1]&R[RS2]
  - 0x05 or: RD=R[RS1]|R[RS2]
  - 0x06 j: PC=PC+4+4*sext([23:16])
  - 0x07 beq: if R[RS1]==R[RS2], PC=PC+4+4*sext([23:16]); else PC+4
  - 0x08 lwd: RD=MEM[R[RS2]]
  - 0x09 lwi: RD=MEM[IMM]
  - 0x0A swd: MEM[R[RS2]]=R[RS1]
  - 0x0B swi: MEM[IMM]=R[RS1]
  - Other opcodes: NOP (PC+4, no writes).
- Non-memory instructions: execute in one cycle. Register write and PC update happen on the rising edge ending the cycle. Register reads are combinational.
- Memory access handshake (internal):
  - READ=1 for lwd/lwi, WRITE=1 for swd/swi, decoded combinationally.
  - ADDRESS is 8-bit. WRITEDATA=R[RS1].
  - The memory counter increments each rising edge while READ|WRITE.
  - BUSYWAIT=(READ|WRITE) && (count != MEM_LATENCY-1), so it is high from the first cycle of the access.
  - While BUSYWAIT=1: PC holds and no register write occurs.
  - Final cycle (count==MEM_LATENCY-1): BUSYWAIT=0 and READDATA=MEM[ADDRESS] is valid combinationally.
  - On that final edge: a store writes memory, a load writes RD, PC advances and the counter clears to 0.
  - Every memory instruction therefore takes exactly MEM_LATENCY cycles.
- Back-to-back memory instructions: each starts a fresh count from 0. There is no overlap and no retrigger of a completed access.
- Simultaneous READ and WRITE cannot occur (decoder is one-hot). If forced, memory treats it as idle.
- Reset mid-access: the access is aborted, no write occurs and the counter is cleared.
- Address wraps naturally within 8 bits. Arithmetic has no flags; overflow wraps.

Test Plan:
1. Assert RESET for 5 time units, then release. -> PC=0; all registers 0; PC advances by 4 per cycle for ALU instructions.
2. Program:
   - lwi r0,0x01
   - loadi r0,0x0C
   - loadi r1,0x0A
   - add r2,r1,r0
   - swd r1,r0
   - loadi r3,0xF7
   - swi r2,0x19
   - sub r4,r1,r2
   - lwd r5,r0
   - lwd r6,r1

   Required response:
   - r0=0x0C, r1=0x0A, r2=0x16, r3=0xF7, r4=0xF4, r5=0x0A, r6=0x00
   - MEM[0x0C]=0x0A, MEM[0x19]=0x16
   - lwi returns 0 from reset memory
3. Timing: each lwi/lwd/swd/swi holds PC for exactly 5 cycles. BUSYWAIT is high for 4 cycles, low in the 5th. An ALU instruction takes 1 cycle.
4. Branch/jump:
   - beq r1,r1 with offset 0x02 -> PC jumps +12.
   - beq with unequal registers -> PC+4.
   - j with offset 0xFF -> PC unchanged (self-loop).
5. Assert RESET during the 3rd cycle of swi. -> Target byte stays 0, PC=0, all registers 0.
6. Opcode 0xFF -> no register/memory change, PC+4.

Source files
------------

// File: rtl/cpu_dmem_system.sv
// rtl/cpu_dmem_system.sv - 8-bit single-cycle CPU core with a busywait data memory
//
// Purpose:
//   Single-cycle 8-bit processor with eight 8-bit registers and an internal
//   byte-wide data memory. Memory accesses stall the core through a busywait
//   handshake. Every load or store occupies exactly MEM_LATENCY cycles.
//
// Ports:
//   CLK          in   1   system clock, rising-edge active
//   RESET        in   1   asynchronous active-high reset
//   PC           out  32  byte address of the current instruction
//   INSTRUCTION  in   32  instruction word at PC, valid combinationally
//
// Instruction fields:
//   [31:24] opcode
//   [23:16] rd or branch offset
//   [15:8]  rs1
//   [7:0]   rs2 or imm
//   Register indices use only the low 3 bits of each field.

module cpu_dmem_system #(
  parameter int MEM_LATENCY = 5,
  parameter int DMEM_DEPTH  = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION
);

  localparam int                CNT_W    = $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;

  // Architectural state
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rf_q  [0:7];
  logic [7:0]       mem_q [0:DMEM_DEPTH-1];

  // Decode
  logic [7:0] opcode;
  logic [7:0] offset;
  logic [7:0] imm;
  logic [2:0] rd_idx;
  logic [2:0] rs1_idx;
  logic [2:0] rs2_idx;
  logic [7:0] rs1_val;
  logic [7:0] rs2_val;

  // Memory handshake
  logic       mem_read;
  logic       mem_write;
  logic       mem_active;
  logic       busywait;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;

  // Register write port
  logic       rf_we;
  logic [7:0] rf_wdata;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  // rs1 field bits above the register index carry no meaning
  logic unused_bits;
  assign unused_bits = ^INSTRUCTION[15:11];

  assign opcode  = INSTRUCTION[31:24];
  assign offset  = INSTRUCTION[23:16];
  assign imm     = INSTRUCTION[7:0];
  assign rd_idx  = INSTRUCTION[18:16];
  assign rs1_idx = INSTRUCTION[10:8];
  assign rs2_idx = INSTRUCTION[2:0];

  assign rs1_val = rf_q[rs1_idx];
  assign rs2_val = rf_q[rs2_idx];

  assign mem_read  = (opcode == OP_LWD) || (opcode == OP_LWI);
  assign mem_write = (opcode == OP_SWD) || (opcode == OP_SWI);

  // A forced read+write combination is treated as an idle memory
  assign mem_active = mem_read ^ mem_write;

  // High from the first cycle of an access; drops only in the final cycle
  assign busywait  = mem_active && (cnt_q != CNT_LAST);

  assign mem_addr  = ((opcode == OP_LWD) || (opcode == OP_SWD)) ? rs2_val : imm;
  assign mem_wdata = rs1_val;
  assign mem_rdata = mem_q[mem_addr];
  assign mem_we    = mem_write && !mem_read && !busywait;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

  // Access counter: counts while an access is in flight, clears on the final cycle
  always_comb begin
    cnt_d = '0;
    if (mem_active && busywait) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next PC: held during busywait
  always_comb begin
    pc_d = pc_plus4;
    if (busywait) begin
      pc_d = pc_q;
    end else if (opcode == OP_J) begin
      pc_d = branch_target;
    end else if ((opcode == OP_BEQ) && (rs1_val == rs2_val)) begin
      pc_d = branch_target;
    end
  end

  // Register write-back
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = 8'h00;
    case (opcode)
      OP_LOADI: begin rf_we = 1'b1; rf_wdata = imm;               end
      OP_MOV:   begin rf_we = 1'b1; rf_wdata = rs2_val;           end
      OP_ADD:   begin rf_we = 1'b1; rf_wdata = rs1_val + rs2_val; end
      OP_SUB:   begin rf_we = 1'b1; rf_wdata = rs1_val - rs2_val; end
      OP_AND:   begin rf_we = 1'b1; rf_wdata = rs1_val & rs2_val; end
      OP_OR:    begin rf_we = 1'b1; rf_wdata = rs1_val | rs2_val; end
      OP_LWD, OP_LWI: begin
        rf_we    = mem_active && !busywait;
        rf_wdata = mem_rdata;
      end
      default: begin
        rf_we    = 1'b0;
        rf_wdata = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 8'h00;
      end
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      if (rf_we) begin
        rf_q[rd_idx] <= rf_wdata;
      end
      if (mem_we) begin
        mem_q[mem_addr] <= mem_wdata;
      end
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_cpu_dmem_system.sv
// tb/tb_cpu_dmem_system.sv - directed self-checking bench for cpu_dmem_system

module tb_cpu_dmem_system;

  localparam int LAT = 5;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] rom [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  cpu_dmem_system #(.MEM_LATENCY(LAT), .DMEM_DEPTH(256)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .PC         (pc),
    .INSTRUCTION(instruction)
  );

  always #5 clk = ~clk;

  always_comb instruction = rom[pc[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered in the first cycle of a memory instruction; leaves in the next instruction
  task automatic mem_op(input string tag, input logic [31:0] pc_at);
    for (int k = 1; k <= LAT; k++) begin
      check($sformatf("%s_pc_c%0d", tag, k), pc, pc_at);
      check($sformatf("%s_busy_c%0d", tag, k), {31'd0, dut.busywait}, {31'd0, (k < LAT)});
      tick();
    end
    check($sformatf("%s_pc_next", tag), pc, pc_at + 32'd4);
  endtask

  task automatic alu(input string tag, input logic [31:0] pc_after, input int r, input logic [7:0] val);
    tick();
    check($sformatf("%s_pc", tag), pc, pc_after);
    check($sformatf("%s_r%0d", tag, r), {24'd0, dut.rf_q[r]}, {24'd0, val});
  endtask

  logic [7:0] exp_rf [0:7];

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hFF00_0000;
    rom[0]  = 32'h0900_0001; // lwi   r0,0x01
    rom[1]  = 32'h0000_000C; // loadi r0,0x0C
    rom[2]  = 32'h0001_000A; // loadi r1,0x0A
    rom[3]  = 32'h0202_0100; // add   r2,r1,r0
    rom[4]  = 32'h0A00_0100; // swd   r1,r0
    rom[5]  = 32'h0003_00F7; // loadi r3,0xF7
    rom[6]  = 32'h0B00_0219; // swi   r2,0x19
    rom[7]  = 32'h0304_0102; // sub   r4,r1,r2
    rom[8]  = 32'h0805_0000; // lwd   r5,r0
    rom[9]  = 32'h0806_0001; // lwd   r6,r1
    rom[10] = 32'h0702_0101; // beq   r1,r1,+2
    rom[11] = 32'h0007_0055; // loadi r7,0x55 (skipped)
    rom[12] = 32'h0007_0066; // loadi r7,0x66 (skipped)
    rom[13] = 32'h0702_0001; // beq   r0,r1,+2 (not taken)
    rom[14] = 32'hFF07_0033; // undefined opcode
    rom[15] = 32'h06FF_0000; // j     -1 (self-loop)

    rst = 1'b1;
    #5;
    rst = 1'b0;
    #1;

    check("reset_pc", pc, 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("reset_r%0d", i), {24'd0, dut.rf_q[i]}, 32'd0);

    mem_op("lwi", 32'd0);
    check("lwi_r0", {24'd0, dut.rf_q[0]}, 32'h00);
    alu("loadi_r0", 32'd8,  0, 8'h0C);
    alu("loadi_r1", 32'd12, 1, 8'h0A);
    alu("add",      32'd16, 2, 8'h16);
    mem_op("swd", 32'd16);
    check("swd_mem0c", {24'd0, dut.mem_q[8'h0C]}, 32'h0A);
    alu("loadi_r3", 32'd24, 3, 8'hF7);
    check("swi_mem19_before", {24'd0, dut.mem_q[8'h19]}, 32'h00);
    mem_op("swi", 32'd24);
    check("swi_mem19", {24'd0, dut.mem_q[8'h19]}, 32'h16);
    alu("sub", 32'd32, 4, 8'hF4);
    mem_op("lwd_r5", 32'd32);
    check("lwd_r5", {24'd0, dut.rf_q[5]}, 32'h0A);
    mem_op("lwd_r6", 32'd36);
    check("lwd_r6", {24'd0, dut.rf_q[6]}, 32'h00);

    tick();
    check("beq_taken_pc", pc, 32'd52);
    check("beq_skip_r7", {24'd0, dut.rf_q[7]}, 32'h00);
    tick();
    check("beq_not_taken_pc", pc, 32'd56);
    tick();
    check("nop_pc", pc, 32'd60);
    exp_rf[0] = 8'h0C; exp_rf[1] = 8'h0A; exp_rf[2] = 8'h16; exp_rf[3] = 8'hF7;
    exp_rf[4] = 8'hF4; exp_rf[5] = 8'h0A; exp_rf[6] = 8'h00; exp_rf[7] = 8'h00;
    for (int i = 0; i < 8; i++)
      check($sformatf("final_r%0d", i), {24'd0, dut.rf_q[i]}, {24'd0, exp_rf[i]});
    check("nop_mem33", {24'd0, dut.mem_q[8'h33]}, 32'h00);
    tick();
    check("jloop_pc1", pc, 32'd60);
    tick();
    check("jloop_pc2", pc, 32'd60);

    // Reset mid-store: new program loadi r2,0x5A ; swi r2,0x30
    rst = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'hFF00_0000;
    rom[0] = 32'h0002_005A;
    rom[1] = 32'h0B00_0230;
    #1;
    check("rst2_mem0c", {24'd0, dut.mem_q[8'h0C]}, 32'h00);
    tick();
    rst = 1'b0;
    tick();
    check("p2_loadi_pc", pc, 32'd4);
    check("p2_loadi_r2", {24'd0, dut.rf_q[2]}, 32'h5A);
    tick();
    tick();
    check("p2_swi_c3_pc", pc, 32'd4);
    check("p2_swi_c3_busy", {31'd0, dut.busywait}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_pc", pc, 32'd0);
    check("midrst_mem30", {24'd0, dut.mem_q[8'h30]}, 32'h00);
    check("midrst_cnt", {29'd0, dut.cnt_q}, 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("midrst_r%0d", i), {24'd0, dut.rf_q[i]}, 32'd0);
    for (int i = 0; i < 64; i++) rom[i] = 32'hFF00_0000;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_pc", pc, 32'd4);
    check("post_rst_mem30", {24'd0, dut.mem_q[8'h30]}, 32'h00);
    check("post_rst_r2", {24'd0, dut.rf_q[2]}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
